// File: rtl/ins_mem_pkg.sv
// rtl/ins_mem_pkg.sv - shared instruction-memory constants and loader state encoding
package ins_mem_pkg;

  localparam int INS_ADDR_W = 12;
  localparam int INS_DATA_W = 32;
  localparam int INS_DEPTH  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4
  } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four stream bytes into one big-endian 32-bit word
//  clk, rst      : clock, synchronous active-high reset
//  clear         : drop any partial word (load start)
//  shift         : accept byte_in this cycle
//  byte_in       : stream byte
//  word          : first three held bytes followed by byte_in, i.e. the full word on the 4th shift
//  word_full     : this shift completes a word
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  // Only three bytes need storing: the fourth is taken straight from byte_in
  // in the cycle it completes the word, and the counter wraps back to zero.
  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {sr[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  assign word      = {sr, byte_in};
  assign word_full = shift && (cnt == 2'd3);

endmodule

// File: rtl/ins_loader.sv
// rtl/ins_loader.sv - byte-stream loader writing 32-bit words into instruction memory
//  Optional macro: LOAD_CHECKSUM_EN (adds CHK state and trailing XOR checksum byte)
//  clk, rst              : clock, synchronous active-high reset
//  start, base_addr,
//  word_count            : load request, sampled only in IDLE/DONE
//  byte_data, byte_valid,
//  byte_ready            : incoming byte stream handshake
//  mem_we, mem_addr,
//  mem_wdata             : instruction memory write port
//  cpu_halt, busy        : load in progress
//  done, err             : completion / error levels
module ins_loader
  import ins_mem_pkg::*;
#(
  parameter int ADDR_W = INS_ADDR_W,
  parameter int DATA_W = INS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         state, state_n;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   words_inc;
  logic              accept;
  logic              idle_like;
  logic              count_ok;
  logic              load_start;
  logic              last_word;
  logic [31:0]       pk_word;
  logic              pk_full;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign accept     = byte_valid && byte_ready;
  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
  assign count_ok   = (word_count != '0) && (word_count <= MAX_COUNT);
  assign load_start = start && idle_like && count_ok;
  assign words_inc  = words_q + 1'b1;
  assign last_word  = (words_inc == count_q);

  // The checksum byte arriving in CHK must not enter the packer.
  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .shift     (accept && (state == ST_RECV)),
    .byte_in   (byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_n = count_ok ? ST_RECV : ST_DONE;
      end
      ST_RECV: begin
        if (pk_full) state_n = ST_WRITE;
      end
      ST_WRITE: begin
`ifdef LOAD_CHECKSUM_EN
        state_n = last_word ? ST_CHK : ST_RECV;
`else
        state_n = last_word ? ST_DONE : ST_RECV;
`endif
      end
      ST_CHK: begin
        if (accept) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
      ST_WRITE: begin mem_we     = 1'b1; busy = 1'b1; end
      ST_CHK:   begin byte_ready = 1'b1; busy = 1'b1; end
      default:  ;
    endcase
  end

  assign cpu_halt = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      count_q   <= '0;
      words_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      if (start && idle_like) begin
        if (count_ok) begin
          base_q  <= base_addr;
          count_q <= word_count;
          words_q <= '0;
          done    <= 1'b0;
          err     <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
          csum_q  <= '0;
`endif
        end else begin
          done <= 1'b1;
          err  <= 1'b1;
        end
      end

      // Address and data are registered on the completing handshake so they
      // are valid throughout WRITE and then hold until the next word.
      if (pk_full) begin
        mem_addr  <= base_q + words_q[ADDR_W-1:0];
        mem_wdata <= pk_word;
      end

      if (state == ST_WRITE) begin
        words_q <= words_inc;
`ifndef LOAD_CHECKSUM_EN
        if (last_word) done <= 1'b1;
`endif
      end

`ifdef LOAD_CHECKSUM_EN
      if (accept && (state == ST_RECV)) csum_q <= csum_q ^ byte_data;
      if (accept && (state == ST_CHK)) begin
        done <= 1'b1;
        if (byte_data != csum_q) err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// tb/tb_ins_loader.sv - self-checking bench for ins_loader
module tb_ins_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic        err;

  ins_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_halt   (cpu_halt),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Observed writes, for the literal per-test expectations.
  logic [11:0] wa[$];
  logic [31:0] wd[$];
  int          busy_hi;

  // Transaction-level model: what the outputs must be next cycle, from the
  // bytes and requests seen on the inputs.
  bit          mon_en;
  bit          m_active, m_done, m_err, m_we_next, m_wait_ck, we_n;
  int          m_base, m_count, m_widx, m_nb;
  bit [31:0]   m_word, m_data_hold;
  bit [11:0]   m_addr_hold;
  bit [7:0]    m_csum;
  bit          ck_build;

  initial begin
`ifdef LOAD_CHECKSUM_EN
    ck_build = 1'b1;
`else
    ck_build = 1'b0;
`endif
  end

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("busy",       32'(busy),       32'(m_active));
      chk("cpu_halt",   32'(cpu_halt),   32'(m_active));
      chk("done",       32'(done),       32'(m_done));
      chk("err",        32'(err),        32'(m_err));
      chk("mem_we",     32'(mem_we),     32'(m_we_next));
      chk("byte_ready", 32'(byte_ready), 32'(m_active && !m_we_next));
      chk("mem_addr",   32'(mem_addr),   32'(m_addr_hold));
      chk("mem_wdata",  mem_wdata,       m_data_hold);
      if (busy === 1'b1) busy_hi++;
      if (mem_we === 1'b1) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end

      if (rst) begin
        m_active = 0; m_done = 0; m_err = 0; m_we_next = 0; m_wait_ck = 0;
        m_nb = 0; m_widx = 0; m_addr_hold = '0; m_data_hold = '0; m_csum = '0;
      end else begin
        we_n = 0;
        if (m_we_next) begin
          m_widx++;
          if (m_widx == m_count) begin
            if (ck_build) m_wait_ck = 1;
            else begin m_active = 0; m_done = 1; end
          end
        end else if (m_active && byte_valid) begin
          if (m_wait_ck) begin
            m_err     = (byte_data != m_csum);
            m_done    = 1;
            m_active  = 0;
            m_wait_ck = 0;
          end else begin
            m_word[31 - 8*m_nb -: 8] = byte_data;
            m_csum = m_csum ^ byte_data;
            m_nb++;
            if (m_nb == 4) begin
              we_n        = 1;
              m_nb        = 0;
              m_addr_hold = 12'((m_base + m_widx) % 4096);
              m_data_hold = m_word;
            end
          end
        end else if (!m_active && start) begin
          if (word_count >= 1 && word_count <= 4096) begin
            m_active = 1; m_base = int'(base_addr); m_count = int'(word_count);
            m_widx = 0; m_nb = 0; m_done = 0; m_err = 0; m_csum = '0; m_wait_ck = 0;
          end else begin
            m_done = 1;
            m_err  = 1;
          end
        end
        m_we_next = we_n;
      end
    end
  end

  logic [7:0] stim[$];

  task automatic do_start(input logic [11:0] b, input logic [12:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        byte_valid = 1'b0; byte_data = 8'hEE;
        @(negedge clk);
      end
    end
    byte_valid = 1'b1; byte_data = b;
    if (pulse) begin
      start = 1'b1; base_addr = 12'h123; word_count = 13'd7;
    end
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 50) chk("send_byte_timeout", 32'(n), 32'd0);
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic load(input logic [11:0] b, input logic [12:0] c, input bit gaps, input int pulse_at);
`ifdef LOAD_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
`endif
    do_start(b, c);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], gaps, i == pulse_at);
`ifdef LOAD_CHECKSUM_EN
      x = x ^ stim[i];
`endif
    end
`ifdef LOAD_CHECKSUM_EN
    send_byte(x, gaps, 1'b0);
`endif
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    byte_data = '0; byte_valid = 1'b0; mon_en = 1'b0; busy_hi = 0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Bytes offered while idle must not be consumed.
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;

    // 1: single word
    wa.delete(); wd.delete();
    stim = '{8'h20, 8'h11, 8'h00, 8'h01};
    load(12'h000, 13'd1, 1'b0, -1);
    chk("t1_nwr", wa.size(), 1);
    if (wa.size() >= 1) begin
      chk("t1_addr", 32'(wa[0]), 32'h000);
      chk("t1_data", wd[0], 32'h20110001);
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_halt", 32'(cpu_halt), 0);

    // 2: two words from 0x005
    wa.delete(); wd.delete();
    stim = '{8'h08, 8'h00, 8'h0C, 8'h09, 8'h20, 8'h11, 8'h00, 8'h01};
    load(12'h005, 13'd2, 1'b0, -1);
    chk("t2_nwr", wa.size(), 2);
    if (wa.size() >= 2) begin
      chk("t2_addr0", 32'(wa[0]), 32'h005);
      chk("t2_data0", wd[0], 32'h08000C09);
      chk("t2_addr1", 32'(wa[1]), 32'h006);
      chk("t2_data1", wd[1], 32'h20110001);
    end

    // 3: address wrap
    wa.delete(); wd.delete();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load(12'hFFF, 13'd2, 1'b0, -1);
    chk("t3_nwr", wa.size(), 2);
    if (wa.size() >= 2) begin
      chk("t3_addr0", 32'(wa[0]), 32'hFFF);
      chk("t3_data0", wd[0], 32'h01020304);
      chk("t3_addr1", 32'(wa[1]), 32'h000);
      chk("t3_data1", wd[1], 32'h05060708);
    end
    chk("t3_err", 32'(err), 0);

    // 4: illegal counts, from DONE (4097) and from IDLE (0)
    wa.delete(); wd.delete(); busy_hi = 0;
    do_start(12'h010, 13'd4097);
    repeat (3) @(negedge clk);
    chk("t4a_err", 32'(err), 1);
    chk("t4a_done", 32'(done), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_done", 32'(done), 0);
    do_start(12'h010, 13'd0);
    repeat (3) @(negedge clk);
    chk("t4b_err", 32'(err), 1);
    chk("t4b_done", 32'(done), 1);
    chk("t4_nwr", wa.size(), 0);
    chk("t4_busy_cycles", busy_hi, 0);

    // 5: random byte gaps, start pulsed mid-load
    wa.delete(); wd.delete();
    stim = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8,
             8'hA9, 8'hAA, 8'hAB, 8'hAC};
    load(12'h010, 13'd3, 1'b1, 5);
    chk("t5_nwr", wa.size(), 3);
    if (wa.size() >= 3) begin
      chk("t5_addr0", 32'(wa[0]), 32'h010);
      chk("t5_data0", wd[0], 32'hA1A2A3A4);
      chk("t5_addr2", 32'(wa[2]), 32'h012);
      chk("t5_data2", wd[2], 32'hA9AAABAC);
    end
    chk("t5_err", 32'(err), 0);

    // 6: reset after two bytes of the first word
    wa.delete(); wd.delete();
    do_start(12'h020, 13'd1);
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(byte_ready), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_addr", 32'(mem_addr), 0);
    chk("t6_wdata", mem_wdata, 0);
    repeat (4) @(negedge clk);
    chk("t6_nwr", wa.size(), 0);

`ifdef LOAD_CHECKSUM_EN
    stim = '{8'h20, 8'h11, 8'h00, 8'h01};
    do_start(12'h000, 13'd1);
    for (int i = 0; i < 4; i++) send_byte(stim[i], 1'b0, 1'b0);
    send_byte(8'h30, 1'b0, 1'b0);
    wait_idle();
    chk("ck_good_err", 32'(err), 0);
    chk("ck_good_done", 32'(done), 1);
    do_start(12'h000, 13'd1);
    for (int i = 0; i < 4; i++) send_byte(stim[i], 1'b0, 1'b0);
    send_byte(8'h31, 1'b0, 1'b0);
    wait_idle();
    chk("ck_bad_err", 32'(err), 1);
    chk("ck_bad_done", 32'(done), 1);
`endif

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
